stepper_driver_model: RTL and testbench
=======================================

Name: stepper_driver_model

Overview:
- Six-channel stepper-driver/axis emulator: the receiving end of the PU/DR/MF motor interface driven by the control system.
- Counts step pulses into per-axis position registers and generates the Stop limit-switch inputs that the controller uses for homing (calibration).
- Used for closed-loop simulation and hardware-in-loop bring-up in place of real drivers and limit switches.
- Flags protocol violations: step while disabled, too-fast stepping, DR not set up before a step, and travel overrun.

Parameters:
- N_AXIS, 6, number of motor channels.
- POS_W, 16, position register width (unsigned).
- POS_MAX, 16'd999, upper travel end (soft stop).
- INIT_POS, {6{16'd500}}, per-axis position after reset; N_AXIS*POS_W vector, axis 0 in the LSBs.
- MIN_GAP, 50, minimum sysclk cycles between accepted rising edges of one axis's PU.
- DR_SETUP, 4, minimum stable cycles of DR before a PU rising edge.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- PU  in  N_AXIS  step pulses; one step per rising edge.
- DR  in  N_AXIS  direction: 1 = increment position, 0 = decrement.
- MF  in  N_AXIS  driver enable: 1 = enabled (steps accepted), 0 = free/disabled.
- Stop  out  N_AXIS  limit switch: 1 while axis position == 0.
- fault  out  N_AXIS  sticky OR of all fault conditions per axis.
- fault_code  out  4  fault cause bits of axis pos_sel: {overrun, dr_setup, gap, disabled}.
- clr_fault  in  1  one-cycle pulse; clears all sticky fault bits.
- pos_sel  in  3  axis index for readback.
- pos_out  out  POS_W  registered position of axis pos_sel.

Behaviour:
- Reset (rst=0, async):
  - pos[i] <= INIT_POS[i]; gap counters saturate to MIN_GAP (first edge is legal); DR stability counters saturate to DR_SETUP.
  - All fault bits 0.
  - Stop <= 1 only for axes whose INIT_POS is 0.
  - pos_out <= 0.
- Input conditioning: PU, DR, MF each pass through a 2-FF synchronizer. Edge detection compares synced PU with its delayed copy. An accepted edge updates pos 3 cycles after the external PU rise.
- Per axis, on a synced PU rising edge:
  - MF=0: no position change; set disabled fault.
  - MF=1, DR=1: pos < POS_MAX -> pos+1. pos == POS_MAX -> hold, set overrun.
  - MF=1, DR=0: pos > 0 -> pos-1. pos == 0 -> hold (hard stop), set overrun.
  - Gap counter < MIN_GAP: step still applied; set gap fault.
  - DR stability counter < DR_SETUP: step applied using the current DR; set dr_setup fault.
- Gap counter: reset to 0 on every PU rising edge regardless of MF; increments each cycle; saturates at MIN_GAP.
- DR stability counter: reset to 0 on any synced DR change; increments each cycle; saturates at DR_SETUP.
- Stop[i]: registered; equals (pos[i]==0) one cycle after pos updates. It stays asserted while the axis rests at 0 and deasserts on the step that leaves 0.
- Faults:
  - Sticky per axis.
  - A clr_fault cycle clears all bits. If a new fault event occurs in the same cycle as clr_fault, the fault wins and the bit stays set.
  - fault[i] = OR of that axis's four cause bits.
- Readback: pos_out <= pos[pos_sel] one cycle later; pos_sel > N_AXIS-1 gives 0. fault_code follows the same registered select rule.
- Axes are fully independent. Simultaneous edges on several axes are all processed in the same cycle.
- Reset mid-step: any in-flight edge in the synchronizers is discarded.

Test Plan:
1. Reset with default INIT_POS, MF=6'b111111, DR=0; drive 500 PU pulses on axis 0 with period 100 cycles -> pos_out(sel=0) steps 500..0; Stop[0]=1 exactly after the 500th step, Stop[5:1]=0; fault=0.
2. Axis 0 at 0 with DR=0, one further pulse -> pos stays 0, Stop[0] stays 1, fault[0]=1, fault_code=4'b1000. Then clr_fault -> fault[0]=0. Then DR=1 (held 10 cycles) plus one pulse -> pos=1, Stop[0]=0.
3. Axis 3 with MF[3]=0, 5 pulses -> pos stays 500, fault_code(sel=3)=4'b0001. Then MF[3]=1, 5 pulses with DR=1 -> pos=505.
4. Axis 2, two pulses 20 cycles apart (MIN_GAP=50) -> both counted (pos 500->498 with DR=0), fault_code(sel=2)=4'b0010. Same-cycle clr_fault plus violating edge -> bit remains 1.
5. Axis 4, DR toggled 2 cycles before a PU edge -> step applied in the new direction, fault_code=4'b0100. Axis 5 driven to 999 then one more up-step -> pos=999, overrun set.
6. Pulses on all six axes in the same cycle, then rst=0 asserted 1 cycle after the PU rise -> after release all pos=500, no faults, no step counted; pos_sel=7 -> pos_out=0.

Source files
------------

// File: rtl/stepper_driver_model.sv
// Six-axis stepper driver / limit-switch emulator: counts PU/DR/MF step traffic into
// per-axis positions, drives Stop at position 0 and flags step-protocol violations.
module stepper_driver_model #(
  parameter int unsigned                    N_AXIS   = 6,
  parameter int unsigned                    POS_W    = 16,
  parameter logic [POS_W-1:0]               POS_MAX  = 16'd999,
  parameter logic [N_AXIS*POS_W-1:0]        INIT_POS = {6{16'd500}},
  parameter int unsigned                    MIN_GAP  = 50,
  parameter int unsigned                    DR_SETUP = 4
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [N_AXIS-1:0] PU,
  input  logic [N_AXIS-1:0] DR,
  input  logic [N_AXIS-1:0] MF,
  output logic [N_AXIS-1:0] Stop,
  output logic [N_AXIS-1:0] fault,
  output logic [3:0]        fault_code,
  input  logic              clr_fault,
  input  logic [2:0]        pos_sel,
  output logic [POS_W-1:0]  pos_out
);

  localparam int unsigned GapW = $clog2(MIN_GAP + 1);
  localparam int unsigned DrW  = $clog2(DR_SETUP + 1);
  localparam logic [GapW-1:0] GapSat = GapW'(MIN_GAP);
  localparam logic [DrW-1:0]  DrSat  = DrW'(DR_SETUP);

  // Fault cause bit positions: {overrun, dr_setup, gap, disabled}
  localparam int unsigned FDis = 0;
  localparam int unsigned FGap = 1;
  localparam int unsigned FDr  = 2;
  localparam int unsigned FOvr = 3;

  logic [N_AXIS-1:0] pu_s1_q, pu_s2_q, pu_dly_q;
  logic [N_AXIS-1:0] dr_s1_q, dr_s2_q, dr_dly_q;
  logic [N_AXIS-1:0] mf_s1_q, mf_s2_q;
  logic [N_AXIS-1:0] pu_rise, dr_chg;

  logic [POS_W-1:0]  pos_q [N_AXIS];
  logic [POS_W-1:0]  pos_d [N_AXIS];
  logic [GapW-1:0]   gap_q [N_AXIS];
  logic [GapW-1:0]   gap_d [N_AXIS];
  logic [DrW-1:0]    drc_q [N_AXIS];
  logic [DrW-1:0]    drc_d [N_AXIS];
  logic [3:0]        flt_q [N_AXIS];
  logic [3:0]        flt_d [N_AXIS];
  logic [3:0]        flt_ev [N_AXIS];
  logic [N_AXIS-1:0] stop_q, stop_d;
  logic [POS_W-1:0]  pos_out_q, pos_out_d;
  logic [3:0]        code_q, code_d;

  assign pu_rise = pu_s2_q & ~pu_dly_q;
  assign dr_chg  = dr_s2_q ^ dr_dly_q;

  always_comb begin
    for (int unsigned i = 0; i < N_AXIS; i++) begin
      pos_d[i]  = pos_q[i];
      gap_d[i]  = gap_q[i];
      drc_d[i]  = drc_q[i];
      flt_ev[i] = 4'b0000;

      if (pu_rise[i]) begin
        gap_d[i] = '0;
      end else if (gap_q[i] < GapSat) begin
        gap_d[i] = gap_q[i] + GapW'(1);
      end

      if (dr_chg[i]) begin
        drc_d[i] = '0;
      end else if (drc_q[i] < DrSat) begin
        drc_d[i] = drc_q[i] + DrW'(1);
      end

      if (pu_rise[i]) begin
        flt_ev[i][FGap] = (gap_q[i] < GapSat);
        if (!mf_s2_q[i]) begin
          flt_ev[i][FDis] = 1'b1;
        end else begin
          flt_ev[i][FDr] = (drc_q[i] < DrSat);
          if (dr_s2_q[i]) begin
            if (pos_q[i] == POS_MAX) flt_ev[i][FOvr] = 1'b1;
            else                     pos_d[i] = pos_q[i] + POS_W'(1);
          end else begin
            if (pos_q[i] == '0) flt_ev[i][FOvr] = 1'b1;
            else                pos_d[i] = pos_q[i] - POS_W'(1);
          end
        end
      end

      // A fault event in the clear cycle survives the clear
      flt_d[i]  = (clr_fault ? 4'b0000 : flt_q[i]) | flt_ev[i];
      stop_d[i] = (pos_q[i] == '0);
      fault[i]  = |flt_q[i];
    end

    pos_out_d = '0;
    code_d    = 4'b0000;
    for (int unsigned i = 0; i < N_AXIS; i++) begin
      if (32'(pos_sel) == i) begin
        pos_out_d = pos_q[i];
        code_d    = flt_q[i];
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      pu_s1_q   <= '0;
      pu_s2_q   <= '0;
      pu_dly_q  <= '0;
      dr_s1_q   <= '0;
      dr_s2_q   <= '0;
      dr_dly_q  <= '0;
      mf_s1_q   <= '0;
      mf_s2_q   <= '0;
      pos_out_q <= '0;
      code_q    <= 4'b0000;
      for (int unsigned i = 0; i < N_AXIS; i++) begin
        pos_q[i]  <= INIT_POS[i*POS_W +: POS_W];
        gap_q[i]  <= GapSat;
        drc_q[i]  <= DrSat;
        flt_q[i]  <= 4'b0000;
        stop_q[i] <= (INIT_POS[i*POS_W +: POS_W] == '0);
      end
    end else begin
      pu_s1_q   <= PU;
      pu_s2_q   <= pu_s1_q;
      pu_dly_q  <= pu_s2_q;
      dr_s1_q   <= DR;
      dr_s2_q   <= dr_s1_q;
      dr_dly_q  <= dr_s2_q;
      mf_s1_q   <= MF;
      mf_s2_q   <= mf_s1_q;
      pos_out_q <= pos_out_d;
      code_q    <= code_d;
      stop_q    <= stop_d;
      for (int unsigned i = 0; i < N_AXIS; i++) begin
        pos_q[i] <= pos_d[i];
        gap_q[i] <= gap_d[i];
        drc_q[i] <= drc_d[i];
        flt_q[i] <= flt_d[i];
      end
    end
  end

  assign Stop       = stop_q;
  assign pos_out    = pos_out_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_stepper_driver_model.sv
// Directed bench for stepper_driver_model: stepping, limits, fault causes, clear priority
// and reset discarding in-flight steps.
module tb_stepper_driver_model;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [5:0]  PU, DR, MF;
  logic [5:0]  Stop, fault;
  logic [3:0]  fault_code;
  logic        clr_fault;
  logic [2:0]  pos_sel;
  logic [15:0] pos_out;

  int checks   = 0;
  int failures = 0;

  stepper_driver_model dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .PU         (PU),
    .DR         (DR),
    .MF         (MF),
    .Stop       (Stop),
    .fault      (fault),
    .fault_code (fault_code),
    .clr_fault  (clr_fault),
    .pos_sel    (pos_sel),
    .pos_out    (pos_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic sel_axis(input logic [2:0] s);
    pos_sel = s;
    wait_cyc(2);
  endtask

  // One step pulse per masked axis: 5 cycles high, 100-cycle period
  task automatic pulse(input logic [5:0] mask);
    @(negedge sysclk);
    PU = PU | mask;
    wait_cyc(5);
    PU = PU & ~mask;
    wait_cyc(95);
  endtask

  initial begin
    rst = 1'b0; PU = '0; DR = '0; MF = 6'h3f; clr_fault = 1'b0; pos_sel = 3'd0;
    wait_cyc(3);
    check_eq("rst_pos_out", 32'(pos_out), 32'd0);
    check_eq("rst_stop", 32'(Stop), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    rst = 1'b1;
    wait_cyc(3);
    check_eq("init_pos0", 32'(pos_out), 32'd500);

    // Test 1: axis 0 down to 0; axis 5 stepped up alongside to reach 999
    DR[5] = 1'b1;
    wait_cyc(10);
    for (int i = 1; i <= 500; i++) begin
      pulse((i <= 499) ? 6'b100001 : 6'b000001);
      if (i == 1)   check_eq("t1_pos_after1", 32'(pos_out), 32'd499);
      if (i == 250) check_eq("t1_pos_after250", 32'(pos_out), 32'd250);
      if (i == 499) begin
        check_eq("t1_pos_after499", 32'(pos_out), 32'd1);
        check_eq("t1_stop_before0", 32'(Stop), 32'd0);
      end
    end
    check_eq("t1_pos_zero", 32'(pos_out), 32'd0);
    check_eq("t1_stop", 32'(Stop), 32'b000001);
    check_eq("t1_fault", 32'(fault), 32'd0);

    // Test 2: step below 0 -> overrun; clear; leave 0 upward
    pulse(6'b000001);
    check_eq("t2_pos_hold", 32'(pos_out), 32'd0);
    check_eq("t2_stop_hold", 32'(Stop[0]), 32'd1);
    check_eq("t2_fault0", 32'(fault[0]), 32'd1);
    check_eq("t2_code", 32'(fault_code), 32'b1000);
    @(negedge sysclk); clr_fault = 1'b1;
    @(negedge sysclk); clr_fault = 1'b0;
    wait_cyc(2);
    check_eq("t2_clr_fault0", 32'(fault[0]), 32'd0);
    check_eq("t2_clr_code", 32'(fault_code), 32'd0);
    DR[0] = 1'b1;
    wait_cyc(10);
    pulse(6'b000001);
    check_eq("t2_pos_up", 32'(pos_out), 32'd1);
    check_eq("t2_stop_off", 32'(Stop[0]), 32'd0);

    // Test 3: disabled axis ignores steps
    sel_axis(3'd3);
    MF[3] = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < 5; i++) pulse(6'b001000);
    check_eq("t3_pos_disabled", 32'(pos_out), 32'd500);
    check_eq("t3_code_disabled", 32'(fault_code), 32'b0001);
    MF[3] = 1'b1; DR[3] = 1'b1;
    wait_cyc(10);
    for (int i = 0; i < 5; i++) pulse(6'b001000);
    check_eq("t3_pos_enabled", 32'(pos_out), 32'd505);
    check_eq("t3_code_sticky", 32'(fault_code), 32'b0001);

    // Test 4: gap violation, then clear in the same cycle as another violating edge
    sel_axis(3'd2);
    check_eq("t4_pos_start", 32'(pos_out), 32'd500);
    @(negedge sysclk); PU[2] = 1'b1;
    wait_cyc(5);  PU[2] = 1'b0;
    wait_cyc(15); PU[2] = 1'b1;
    wait_cyc(5);  PU[2] = 1'b0;
    wait_cyc(10);
    check_eq("t4_pos_two", 32'(pos_out), 32'd498);
    check_eq("t4_code_gap", 32'(fault_code), 32'b0010);
    wait_cyc(5);
    PU[2] = 1'b1;
    wait_cyc(2);  clr_fault = 1'b1;
    wait_cyc(1);  clr_fault = 1'b0;
    wait_cyc(2);  PU[2] = 1'b0;
    wait_cyc(5);
    check_eq("t4_pos_three", 32'(pos_out), 32'd497);
    check_eq("t4_code_wins", 32'(fault_code), 32'b0010);
    check_eq("t4_fault2", 32'(fault[2]), 32'd1);

    // Test 5: DR changed 2 cycles before the step; then overrun at POS_MAX
    sel_axis(3'd4);
    DR[4] = 1'b1;
    wait_cyc(2);  PU[4] = 1'b1;
    wait_cyc(5);  PU[4] = 1'b0;
    wait_cyc(10);
    check_eq("t5_pos_newdir", 32'(pos_out), 32'd501);
    check_eq("t5_code_dr", 32'(fault_code), 32'b0100);
    sel_axis(3'd5);
    check_eq("t5_pos_max", 32'(pos_out), 32'd999);
    pulse(6'b100000);
    check_eq("t5_pos_hold_max", 32'(pos_out), 32'd999);
    check_eq("t5_code_ovr", 32'(fault_code), 32'b1000);
    check_eq("t5_fault_vec", 32'(fault), 32'b110100);

    // Test 6: reset one cycle after a six-axis step rise discards the step
    @(negedge sysclk); PU = 6'h3f;
    @(negedge sysclk); rst = 1'b0; PU = '0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);
    check_eq("t6_fault", 32'(fault), 32'd0);
    check_eq("t6_stop", 32'(Stop), 32'd0);
    for (int a = 0; a < 6; a++) begin
      sel_axis(3'(a));
      check_eq($sformatf("t6_pos_axis%0d", a), 32'(pos_out), 32'd500);
    end
    sel_axis(3'd7);
    check_eq("t6_sel7_pos", 32'(pos_out), 32'd0);
    check_eq("t6_sel7_code", 32'(fault_code), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
